// File: rtl/wreg_hazard_tracker.sv
// Write-register hazard tracker for a five-stage pipeline.
// Each of E, M and W carries a destination register and a Tnew count (cycles
// until that stage's result can be forwarded). The D-stage sources are compared
// against those entries to produce a zero-latency stall and forwarding selects.
// Register 0 is never tracked, and a Tuse of all ones means "source not read".
module wreg_hazard_tracker #(
   parameter int AW = 5,
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] id_wa,
   input  logic          id_we,
   input  logic [TW-1:0] id_tnew,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic [TW-1:0] id_rs_tuse,
   input  logic [TW-1:0] id_rt_tuse,
   output logic          stall,
   output logic [1:0]    fwd_rs_sel,
   output logic [1:0]    fwd_rt_sel,
   output logic [AW-1:0] e_wa,
   output logic [AW-1:0] m_wa,
   output logic [AW-1:0] w_wa
);

   // Stage codes used on the forwarding selects.
   localparam logic [1:0] SEL_RF = 2'd0;
   localparam logic [1:0] SEL_E  = 2'd1;
   localparam logic [1:0] SEL_M  = 2'd2;
   localparam logic [1:0] SEL_W  = 2'd3;

   logic [AW-1:0] wa_e, wa_m, wa_w;
   logic [TW-1:0] tnew_e, tnew_m, tnew_w;
   logic          rs_stall, rt_stall;

   // Saturating decrement: a result that is ready stays ready.
   function automatic logic [TW-1:0] sat0(input logic [TW-1:0] t);
      sat0 = (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Resolve one source: the youngest matching stage wins; returns {stall, sel}.
   // A source of 0 or an unused source (tuse all ones) never matches.
   function automatic logic [2:0] resolve(
      input logic [AW-1:0] src,
      input logic [TW-1:0] tuse,
      input logic [AW-1:0] we_a, input logic [TW-1:0] we_t,
      input logic [AW-1:0] wm_a, input logic [TW-1:0] wm_t,
      input logic [AW-1:0] ww_a, input logic [TW-1:0] ww_t
   );
      logic [1:0]    win;
      logic [TW-1:0] t;
      win = SEL_RF;
      t   = '0;
      if (src != '0 && tuse != '1) begin
         if (src == we_a) begin
            win = SEL_E;
            t   = we_t;
         end else if (src == wm_a) begin
            win = SEL_M;
            t   = wm_t;
         end else if (src == ww_a) begin
            win = SEL_W;
            t   = ww_t;
         end
      end
      resolve = {(win != SEL_RF) && (t > tuse),
                 ((win != SEL_RF) && (t == '0)) ? win : SEL_RF};
   endfunction

   // Hazard resolution for rs and rt against the in-flight stages.
   always_comb begin
      {rs_stall, fwd_rs_sel} = resolve(id_rs, id_rs_tuse, wa_e, tnew_e,
                                       wa_m, tnew_m, wa_w, tnew_w);
      {rt_stall, fwd_rt_sel} = resolve(id_rt, id_rt_tuse, wa_e, tnew_e,
                                       wa_m, tnew_m, wa_w, tnew_w);
      stall = rs_stall | rt_stall;
   end

   // Pipeline advance: M and W always move; E takes a bubble while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wa_e   <= '0;
         tnew_e <= '0;
         wa_m   <= '0;
         tnew_m <= '0;
         wa_w   <= '0;
         tnew_w <= '0;
      end else begin
         wa_w   <= wa_m;
         tnew_w <= sat0(tnew_m);
         wa_m   <= wa_e;
         tnew_m <= sat0(tnew_e);
         if (stall) begin
            wa_e   <= '0;
            tnew_e <= '0;
         end else begin
            wa_e   <= id_we ? id_wa : '0;
            tnew_e <= id_tnew;
         end
      end
   end

   assign e_wa = wa_e;
   assign m_wa = wa_m;
   assign w_wa = wa_w;

endmodule

// File: tb/tb_wreg_hazard_tracker.sv
// Directed bench for wreg_hazard_tracker: load-use, branch-after-load, ALU chain,
// stage priority, register zero / unused sources, reset mid-stall, and a random
// stream of non-hazard writes followed through to the W-stage write address.
module tb_wreg_hazard_tracker;

   localparam int AW = 5;
   localparam int TW = 2;

   logic          clk;
   logic          reset;
   logic [AW-1:0] id_wa;
   logic          id_we;
   logic [TW-1:0] id_tnew;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic [TW-1:0] id_rs_tuse;
   logic [TW-1:0] id_rt_tuse;
   logic          stall;
   logic [1:0]    fwd_rs_sel;
   logic [1:0]    fwd_rt_sel;
   logic [AW-1:0] e_wa;
   logic [AW-1:0] m_wa;
   logic [AW-1:0] w_wa;

   int n_vec = 0;
   int n_err = 0;
   logic [AW-1:0] exp_q[$];

   wreg_hazard_tracker #(.AW(AW), .TW(TW)) dut (
      .clk        (clk),
      .reset      (reset),
      .id_wa      (id_wa),
      .id_we      (id_we),
      .id_tnew    (id_tnew),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_tuse (id_rs_tuse),
      .id_rt_tuse (id_rt_tuse),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .e_wa       (e_wa),
      .m_wa       (m_wa),
      .w_wa       (w_wa)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // drive the D-stage instruction
   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [TW-1:0] tn,
                        input logic [AW-1:0] rs, input logic [TW-1:0] rs_tu,
                        input logic [AW-1:0] rt, input logic [TW-1:0] rt_tu);
      id_we      = we;
      id_wa      = wa;
      id_tnew    = tn;
      id_rs      = rs;
      id_rs_tuse = rs_tu;
      id_rt      = rt;
      id_rt_tuse = rt_tu;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, '0, '0, 2'd3, '0, 2'd3);
         step();
      end
   endtask

   task automatic check_out(input string tag, input logic s, input logic [1:0] frs,
                            input logic [1:0] frt);
      check({tag, ".stall"}, 32'(stall), 32'(s));
      check({tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(frs));
      check({tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(frt));
   endtask

   initial begin
      // reset with random D inputs
      reset = 1'b0;
      drive(1'b1, AW'($urandom_range(1, 31)), TW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 31)), TW'($urandom_range(0, 3)),
            AW'($urandom_range(0, 31)), TW'($urandom_range(0, 3)));
      repeat (2) step();
      check_out("rst", 1'b0, 2'd0, 2'd0);
      check("rst.e_wa", 32'(e_wa), 0);
      check("rst.m_wa", 32'(m_wa), 0);
      check("rst.w_wa", 32'(w_wa), 0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // load-use: lw $8 (tnew 2); addu reads rs=$8, tuse 1
      drive(1'b1, 5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b1, 5'd10, 2'd1, 5'd8, 2'd1, 5'd0, 2'd3);
      check_out("lu.c0", 1'b1, 2'd0, 2'd0);
      check("lu.e_wa", 32'(e_wa), 8);
      step();
      // lw now in M with tnew 1: no stall, value not yet forwardable in D
      check_out("lu.c1", 1'b0, 2'd0, 2'd0);
      check("lu.e_bubble", 32'(e_wa), 0);
      check("lu.m_wa", 32'(m_wa), 8);
      step();
      // addu in E, lw in W; a new reader of $8 in D forwards from W
      drive(1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd3);
      check_out("lu.c2", 1'b0, 2'd3, 2'd0);
      check("lu.w_wa", 32'(w_wa), 8);
      check("lu.e_wa2", 32'(e_wa), 10);
      step();
      idle(3);

      // branch after load: tnew 2, rs tuse 0 -> two stall cycles
      drive(1'b1, 5'd4, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b0, 5'd0, 2'd0, 5'd4, 2'd0, 5'd0, 2'd3);
      check_out("br.c0", 1'b1, 2'd0, 2'd0);
      step();
      check_out("br.c1", 1'b1, 2'd0, 2'd0);
      step();
      check_out("br.c2", 1'b0, 2'd3, 2'd0);
      step();
      idle(3);

      // ALU chain: addu $9 (tnew 1); subu reads rt=$9 tuse 1
      drive(1'b1, 5'd9, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b1, 5'd11, 2'd1, 5'd0, 2'd3, 5'd9, 2'd1);
      check_out("alu.c0", 1'b0, 2'd0, 2'd0);
      step();
      drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd9, 2'd1);
      check_out("alu.c1", 1'b0, 2'd0, 2'd2);
      step();
      idle(3);

      // priority: $5 in E (tnew 0) and in W; middle instr writes $0 with tnew 2
      drive(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b1, 5'd0, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 5'd5, 2'd3);
      check_out("pri.e_wins", 1'b0, 2'd1, 2'd0);
      check("pri.m_zero", 32'(m_wa), 0);
      drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      check_out("zero.read", 1'b0, 2'd0, 2'd0);
      step();
      idle(3);

      // youngest match decides: E=$7 tnew0 shadows M=$7 tnew1
      drive(1'b1, 5'd7, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b1, 5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd3);
      check_out("young", 1'b0, 2'd1, 2'd0);
      step();
      idle(3);

      // unused source never stalls; the other source still can; then reset mid-stall
      drive(1'b1, 5'd6, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      step();
      drive(1'b0, 5'd0, 2'd0, 5'd6, 2'd3, 5'd0, 2'd0);
      check_out("unused", 1'b0, 2'd0, 2'd0);
      drive(1'b0, 5'd0, 2'd0, 5'd6, 2'd3, 5'd6, 2'd1);
      check_out("rt.stall", 1'b1, 2'd0, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mid.stall", 32'(stall), 0);
      check("rst_mid.e_wa", 32'(e_wa), 0);
      check("rst_mid.m_wa", 32'(m_wa), 0);
      check("rst_mid.w_wa", 32'(w_wa), 0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // random non-hazard writes followed through to w_wa
      for (int i = 0; i < 24; i++) begin
         logic          we;
         logic [AW-1:0] wa;
         we = 1'($urandom_range(0, 1));
         wa = AW'($urandom_range(0, 31));
         drive(we, wa, TW'($urandom_range(0, 3)), 5'd0, 2'd3, 5'd0, 2'd3);
         exp_q.push_back(we ? wa : '0);
         step();
         if (exp_q.size() == 3) check("rnd.w_wa", 32'(w_wa), 32'(exp_q.pop_front()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
